eth_switch_2x2: RTL and testbench
=================================

Name: eth_switch_2x2

Overview:
- 2-input, 2-output packet switch (ports A and B) that sits between two ingress links and two egress consumers.
- Each ingress packet is routed by a destination tag in its SOP word into a per-output FIFO.
- Consumers drain the FIFOs with rd_en.
- Contention and full FIFOs are signalled back to the sources through portAstall and portBstall.

Parameters:
- DATA_WIDTH, 32, width of data words.
- PORT_COUNT, 2, number of output ports and width of the rd_en array (fixed at 2).
- FIFO_DEPTH, 8, words per output FIFO (power of 2).
- ADDR_A, 16'hABCD, destination tag selecting output A.
- ADDR_B, 16'hEFEF, destination tag selecting output B.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-high reset (asserted when 1).
- indataA  in  DATA_WIDTH  ingress A data word.
- insopA  in  1  ingress A start of packet.
- ineopA  in  1  ingress A end of packet.
- indataB  in  DATA_WIDTH  ingress B data word.
- insopB  in  1  ingress B start of packet.
- ineopB  in  1  ingress B end of packet.
- rd_en  in  1 x PORT_COUNT (unpacked array)  rd_en[0] pops output A, rd_en[1] pops output B.
- outdataA  out  DATA_WIDTH  egress A data word.
- outsopA  out  1  egress A start of packet.
- outeopA  out  1  egress A end of packet.
- outdataB  out  DATA_WIDTH  egress B data word.
- outsopB  out  1  egress B start of packet.
- outeopB  out  1  egress B end of packet.
- portAstall  out  1  ingress A word not accepted this cycle.
- portBstall  out  1  ingress B word not accepted this cycle.

Behaviour:
- Reset (rstn=1, asynchronous):
  - FIFOs empty, route locks cleared, both ingress states IDLE.
  - All outputs 0.
- Ingress word valid rules:
  - In IDLE, a word is valid only when insop=1.
  - In BUSY, every cycle is a valid word.
  - insop=ineop=1 is a one-word packet.
- Routing on the SOP word: indata[15:0]==ADDR_A targets output A; ==ADDR_B targets output B; any other value targets DROP.
  - Upper bits are ignored.
  - The route is held until the EOP word.
- Ingress state machine per port:
  - IDLE goes to BUSY on an accepted SOP word without EOP.
  - BUSY returns to IDLE on an accepted EOP word.
  - insop seen while BUSY is ignored; the word is treated as payload.
- DROP packets:
  - Always accepted, never stall, nothing written.
- Output lock:
  - An output is owned by one ingress from the accepted SOP word through the accepted EOP word.
  - Words of different packets never interleave.
- Arbitration, applied when both ingresses present a SOP to the same free output in the same cycle:
  - Round-robin; the pointer starts at A after reset and toggles after each grant.
  - The loser stalls.
- Acceptance and stall (combinational, same cycle):
  - A valid word is accepted when its target is owned by or granted to its ingress and the target FIFO is not full.
  - Otherwise portXstall=1 and nothing is written.
  - The source must hold data, sop and eop stable until stall deasserts.
  - Stall is 0 when no valid word is presented.
- FIFO write: each FIFO entry is {sop,eop,data}; at most one write per FIFO per cycle.
- Simultaneous read and write on a full FIFO:
  - The write is accepted, because the pop frees the slot in the same cycle.
- Read side:
  - rd_en[i]=1 with FIFO i non-empty pops one entry.
  - On the next clock, outdata/outsop/outeop show the popped entry (1-cycle latency).
  - In a cycle with no pop, outsop=outeop=0 and outdata holds its last value.
  - rd_en on an empty FIFO is ignored.
- Reset asserted mid-packet clears everything; a partially stored packet is discarded.

Optional Feature:
- ETH_SW_DROP_CNT_EN.
- When defined, adds outputs dropcntA and dropcntB (16 bits each, reset 0).
  - Each counter increments once per dropped packet, counted at its SOP, on its ingress.
  - Counters saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package eth_sw_pkg holds:
  - DATA_WIDTH, PORT_COUNT, ADDR_A, ADDR_B.
  - A route enum {ROUTE_A, ROUTE_B, ROUTE_DROP}.
  - An ingress state enum {IDLE, BUSY}.
  - A packed FIFO entry struct {sop, eop, data}.
- One sub-module, eth_sw_fifo: synchronous FIFO with full/empty flags and a registered read output; instantiated twice.

Test Plan:
- Reset: rstn=1 at t=0 → all outputs 0, both stalls 0; rd_en[0]=1 on empty → outsopA stays 0.
- A sends one-word packet 32'h0000ABCD (sop=eop=1), then rd_en[0]=1 → next cycle outdataA=32'h0000ABCD, outsopA=outeopA=1; FIFO B unchanged.
- A sends 32'h0000EFEF and B sends 32'h0000EFEF in the same cycle after reset → A granted, portBstall=1; B held one cycle then accepted; rd_en[1] twice returns A then B.
- A sends 32'h00001234 (sop=eop=1) → portAstall=0, nothing stored; rd_en both → no outsop; with ETH_SW_DROP_CNT_EN, dropcntA=1.
- Fill FIFO A with 8 packets tagged 32'h0000ABCD, no reads → 9th gets portAstall=1; rd_en[0]=1 in the same cycle → accepted.
- Multi-word packet from A: ABCD (sop), 32'h11111111, 32'h22222222 (eop), while B sends ABCD mid-packet → B stalled until after A's EOP; readout order is A's three words, then B's.

Source files
------------

// File: rtl/eth_switch_2x2_pkg.sv
// Shared types and constants for the 2x2 packet switch: route/ingress enums,
// FIFO entry layout and the SOP tag decoder.
package eth_sw_pkg;

    localparam int          DATA_WIDTH = 32;
    localparam int          PORT_COUNT = 2;
    localparam logic [15:0] ADDR_A     = 16'hABCD;
    localparam logic [15:0] ADDR_B     = 16'hEFEF;

    typedef enum logic [1:0] {ROUTE_A, ROUTE_B, ROUTE_DROP} route_e;

    typedef enum logic {IDLE, BUSY} ing_state_e;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    function automatic route_e decode_route(input logic [15:0] tag);
        if (tag == ADDR_A) return ROUTE_A;
        if (tag == ADDR_B) return ROUTE_B;
        return ROUTE_DROP;
    endfunction

endpackage

// File: rtl/eth_switch_2x2_if.sv
// Ingress/egress signal bundle of the switch. ETH_SW_DROP_CNT_EN adds the
// per-ingress drop counters.
interface eth_sw_if;
    import eth_sw_pkg::*;

    logic [DATA_WIDTH-1:0] indataA, indataB;
    logic                  insopA, ineopA, insopB, ineopB;
    logic                  rd_en [PORT_COUNT];
    logic [DATA_WIDTH-1:0] outdataA, outdataB;
    logic                  outsopA, outeopA, outsopB, outeopB;
    logic                  portAstall, portBstall;
`ifdef ETH_SW_DROP_CNT_EN
    logic [15:0]           dropcntA, dropcntB;
`endif

    modport master (
        output indataA, insopA, ineopA, indataB, insopB, ineopB, rd_en,
`ifdef ETH_SW_DROP_CNT_EN
        input  dropcntA, dropcntB,
`endif
        input  outdataA, outsopA, outeopA, outdataB, outsopB, outeopB, portAstall, portBstall
    );

    modport slave (
        input  indataA, insopA, ineopA, indataB, insopB, ineopB, rd_en,
`ifdef ETH_SW_DROP_CNT_EN
        output dropcntA, dropcntB,
`endif
        output outdataA, outsopA, outeopA, outdataB, outsopB, outeopB, portAstall, portBstall
    );

endinterface

// File: rtl/eth_switch_2x2_fifo.sv
// Synchronous FIFO of {sop,eop,data} entries with a registered read port.
// The read register clears sop/eop on idle cycles but keeps the data.
module eth_sw_fifo
    import eth_sw_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  fifo_entry_t wr_data_i,
    input  logic        rd_en_i,
    output fifo_entry_t rd_data_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    fifo_entry_t   dout_q;
    logic          wr_fire, rd_fire;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_fire   = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the write.
    assign wr_fire   = wr_en_i && (!full_o || rd_fire);
    assign rd_data_o = dout_q;

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) begin
                dout_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
                dout_q.sop <= 1'b0;
                dout_q.eop <= 1'b0;
            end
            count_q <= count_q + CW'(wr_fire) - CW'(rd_fire);
        end
    end

endmodule

// File: rtl/eth_switch_2x2.sv
// 2x2 packet switch: SOP-tag routing, per-output lock with round-robin
// arbitration, per-output FIFOs. Optional drop counters: ETH_SW_DROP_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a SOP word; only insop=1 marks a valid word
// BUSY  | inside a packet; every cycle is a payload word, route held
module eth_switch_2x2
    import eth_sw_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic    clk,
    input  logic    rstn,
    eth_sw_if.slave bus
);
    logic [DATA_WIDTH-1:0] in_data [2];
    logic                  in_sop  [2];
    logic                  in_eop  [2];

    ing_state_e state_q [2], state_d [2];
    route_e     route_q [2], route_d [2];
    logic       lock_q  [2], lock_d  [2];
    logic       owner_q [2], owner_d [2];
    logic       rr_q, rr_d;

    logic        sop_word [2];
    logic        valid    [2];
    logic        accept   [2];
    route_e      tgt      [2];
    logic        hit      [2][2];
    logic        req      [2][2];
    logic        grant    [2][2];
    logic        contend  [2];
    logic        full     [2];
    logic        empty    [2];
    logic        space    [2];
    logic        wr_en    [2];
    fifo_entry_t wr_entry [2];
    fifo_entry_t rd_entry [2];

    assign in_data[0] = bus.indataA;
    assign in_data[1] = bus.indataB;
    assign in_sop[0]  = bus.insopA;
    assign in_sop[1]  = bus.insopB;
    assign in_eop[0]  = bus.ineopA;
    assign in_eop[1]  = bus.ineopB;

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_d     = rr_q;

        for (int x = 0; x < 2; x++) begin
            sop_word[x] = (state_q[x] == IDLE) && in_sop[x];
            valid[x]    = (state_q[x] == BUSY) || in_sop[x];
            tgt[x]      = (state_q[x] == BUSY) ? route_q[x] : decode_route(in_data[x][15:0]);
            hit[x][0]   = (tgt[x] == ROUTE_A);
            hit[x][1]   = (tgt[x] == ROUTE_B);
        end

        for (int o = 0; o < 2; o++) begin
            space[o]    = !full[o] || (bus.rd_en[o] && !empty[o]);
            req[0][o]   = sop_word[0] && hit[0][o] && !lock_q[o];
            req[1][o]   = sop_word[1] && hit[1][o] && !lock_q[o];
            contend[o]  = req[0][o] && req[1][o];
            grant[0][o] = req[0][o] && (!req[1][o] || !rr_q);
            grant[1][o] = req[1][o] && (!req[0][o] || rr_q);
        end

        for (int x = 0; x < 2; x++) begin
            accept[x] = 1'b0;
            if (valid[x]) begin
                if (tgt[x] == ROUTE_DROP) begin
                    accept[x] = 1'b1;
                end else begin
                    for (int o = 0; o < 2; o++) begin
                        if (hit[x][o]) begin
                            accept[x] = ((state_q[x] == BUSY && lock_q[o] && owner_q[o] == 1'(x))
                                         || grant[x][o]) && space[o];
                        end
                    end
                end
            end
        end

        for (int o = 0; o < 2; o++) begin
            wr_en[o]    = 1'b0;
            wr_entry[o] = '0;
            for (int x = 0; x < 2; x++) begin
                if (accept[x] && hit[x][o]) begin
                    wr_en[o]    = 1'b1;
                    wr_entry[o] = {sop_word[x], in_eop[x], in_data[x]};
                    if (sop_word[x] && !in_eop[x]) begin
                        lock_d[o]  = 1'b1;
                        owner_d[o] = 1'(x);
                    end else if (state_q[x] == BUSY && in_eop[x]) begin
                        lock_d[o] = 1'b0;
                    end
                end
            end
            if (contend[o] && ((accept[0] && grant[0][o]) || (accept[1] && grant[1][o])))
                rr_d = !rr_q;
        end

        for (int x = 0; x < 2; x++) begin
            if (accept[x]) begin
                if (sop_word[x] && !in_eop[x]) begin
                    state_d[x] = BUSY;
                    route_d[x] = tgt[x];
                end else if (state_q[x] == BUSY && in_eop[x]) begin
                    state_d[x] = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int x = 0; x < 2; x++) begin
                state_q[x] <= IDLE;
                route_q[x] <= ROUTE_DROP;
                lock_q[x]  <= 1'b0;
                owner_q[x] <= 1'b0;
            end
            rr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    for (genvar o = 0; o < PORT_COUNT; o++) begin : g_fifo
        eth_sw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rstn),
            .wr_en_i   (wr_en[o]),
            .wr_data_i (wr_entry[o]),
            .rd_en_i   (bus.rd_en[o]),
            .rd_data_o (rd_entry[o]),
            .full_o    (full[o]),
            .empty_o   (empty[o])
        );
    end

    assign bus.outdataA   = rd_entry[0].data;
    assign bus.outsopA    = rd_entry[0].sop;
    assign bus.outeopA    = rd_entry[0].eop;
    assign bus.outdataB   = rd_entry[1].data;
    assign bus.outsopB    = rd_entry[1].sop;
    assign bus.outeopB    = rd_entry[1].eop;
    assign bus.portAstall = valid[0] && !accept[0];
    assign bus.portBstall = valid[1] && !accept[1];

`ifdef ETH_SW_DROP_CNT_EN
    logic [15:0] dropcnt_q [2];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            dropcnt_q[0] <= '0;
            dropcnt_q[1] <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (accept[x] && sop_word[x] && tgt[x] == ROUTE_DROP && dropcnt_q[x] != 16'hFFFF)
                    dropcnt_q[x] <= dropcnt_q[x] + 16'd1;
            end
        end
    end

    assign bus.dropcntA = dropcnt_q[0];
    assign bus.dropcntB = dropcnt_q[1];
`endif

endmodule

// File: tb/tb_eth_switch_2x2.sv
// Randomized bench for eth_switch_2x2 with a packet-level reference model
// (per-output queues, output ownership, round-robin pointer) plus directed cases.
module tb_eth_switch_2x2;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    eth_sw_if bus();

    eth_switch_2x2 #(.FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // stimulus for the next step
    logic [31:0] d_in  [2];
    logic        s_in  [2];
    logic        e_in  [2];
    logic        rd_in [2];

    // reference model
    ent_t        mq [2][$];
    int          m_owner [2];
    bit          m_busy  [2];
    int          m_route [2];
    int          m_rr;
    logic [31:0] exp_data [2];
    logic        exp_sop  [2];
    logic        exp_eop  [2];
    bit          last_acc [2];
`ifdef ETH_SW_DROP_CNT_EN
    int          m_drop [2];
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int route_of(input logic [15:0] tag);
        if (tag == 16'hABCD) return 0;
        if (tag == 16'hEFEF) return 1;
        return 2;
    endfunction

    task automatic set_idle();
        for (int s = 0; s < 2; s++) begin
            d_in[s] = '0; s_in[s] = 1'b0; e_in[s] = 1'b0; rd_in[s] = 1'b0;
        end
    endtask

    task automatic set_word(input int s, input logic [31:0] d, input logic so, input logic eo);
        d_in[s] = d; s_in[s] = so; e_in[s] = eo;
    endtask

    task automatic apply();
        bus.indataA  = d_in[0]; bus.insopA = s_in[0]; bus.ineopA = e_in[0];
        bus.indataB  = d_in[1]; bus.insopB = s_in[1]; bus.ineopB = e_in[1];
        bus.rd_en[0] = rd_in[0];
        bus.rd_en[1] = rd_in[1];
    endtask

    task automatic model_clear();
        for (int o = 0; o < 2; o++) begin
            mq[o].delete();
            m_owner[o] = -1; m_busy[o] = 1'b0; m_route[o] = 2;
            exp_data[o] = '0; exp_sop[o] = 1'b0; exp_eop[o] = 1'b0;
`ifdef ETH_SW_DROP_CNT_EN
            m_drop[o] = 0;
`endif
        end
        m_rr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        apply();
        #1;
        chk("rst_outdataA", bus.outdataA, 32'd0);
        chk("rst_outdataB", bus.outdataB, 32'd0);
        chk("rst_outsopA", 32'(bus.outsopA), 32'd0);
        chk("rst_outsopB", 32'(bus.outsopB), 32'd0);
        chk("rst_outeopA", 32'(bus.outeopA), 32'd0);
        chk("rst_stallA", 32'(bus.portAstall), 32'd0);
        chk("rst_stallB", 32'(bus.portBstall), 32'd0);
`ifdef ETH_SW_DROP_CNT_EN
        chk("rst_dropcntA", 32'(bus.dropcntA), 32'd0);
`endif
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: check egress against the model, drive inputs, predict stalls.
    task automatic step();
        bit   pop   [2];
        bit   space [2];
        bit   valid [2];
        bit   first [2];
        bit   acc   [2];
        int   rt    [2];
        bit   cont;
        int   win;
        ent_t e;
        @(negedge clk);
        chk("outdataA", bus.outdataA, exp_data[0]);
        chk("outsopA", 32'(bus.outsopA), 32'(exp_sop[0]));
        chk("outeopA", 32'(bus.outeopA), 32'(exp_eop[0]));
        chk("outdataB", bus.outdataB, exp_data[1]);
        chk("outsopB", 32'(bus.outsopB), 32'(exp_sop[1]));
        chk("outeopB", 32'(bus.outeopB), 32'(exp_eop[1]));
`ifdef ETH_SW_DROP_CNT_EN
        chk("dropcntA", 32'(bus.dropcntA), 32'(m_drop[0]));
        chk("dropcntB", 32'(bus.dropcntB), 32'(m_drop[1]));
`endif
        apply();
        #1;
        for (int o = 0; o < 2; o++) begin
            pop[o]   = rd_in[o] && (mq[o].size() > 0);
            space[o] = (mq[o].size() < DEPTH) || pop[o];
        end
        for (int s = 0; s < 2; s++) begin
            first[s] = !m_busy[s] && s_in[s];
            valid[s] = m_busy[s] || s_in[s];
            rt[s]    = m_busy[s] ? m_route[s] : route_of(d_in[s][15:0]);
        end
        cont = first[0] && first[1] && rt[0] == rt[1] && rt[0] != 2 && m_owner[rt[0]] < 0;
        win  = m_rr;
        for (int s = 0; s < 2; s++) begin
            acc[s] = 1'b0;
            if (valid[s]) begin
                if (rt[s] == 2)                acc[s] = 1'b1;
                else if (!first[s])            acc[s] = space[rt[s]];
                else if (m_owner[rt[s]] >= 0)  acc[s] = 1'b0;
                else if (cont)                 acc[s] = (s == win) && space[rt[s]];
                else                           acc[s] = space[rt[s]];
            end
        end
        chk("portAstall", 32'(bus.portAstall), 32'(valid[0] && !acc[0]));
        chk("portBstall", 32'(bus.portBstall), 32'(valid[1] && !acc[1]));

        for (int o = 0; o < 2; o++) begin
            if (pop[o]) begin
                e = mq[o].pop_front();
                exp_data[o] = e.data; exp_sop[o] = e.sop; exp_eop[o] = e.eop;
            end else begin
                exp_sop[o] = 1'b0; exp_eop[o] = 1'b0;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
                if (rt[s] != 2) begin
                    e = {first[s], e_in[s], d_in[s]};
                    mq[rt[s]].push_back(e);
                end
                if (first[s] && !e_in[s]) begin
                    m_busy[s] = 1'b1; m_route[s] = rt[s];
                    if (rt[s] != 2) m_owner[rt[s]] = s;
                end else if (!first[s] && e_in[s]) begin
                    m_busy[s] = 1'b0;
                    if (rt[s] != 2) m_owner[rt[s]] = -1;
                end
`ifdef ETH_SW_DROP_CNT_EN
                if (first[s] && rt[s] == 2 && m_drop[s] < 16'hFFFF) m_drop[s]++;
`endif
            end
        end
        if (cont && acc[win]) m_rr = 1 - m_rr;
        last_acc = acc;
    endtask

    // random-phase driver state
    logic [31:0] pw  [2][4];
    logic        pso [2][4];
    int          plen [2];
    int          pidx [2];
    bit          pact [2];
    int          hold [2];
    bit          stuck;
    logic [15:0] tag;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        apply();

        // reset state, read on empty FIFO
        do_reset();
        rd_in[0] = 1'b1;
        step();
        set_idle();
        step();
        chk("t1_outsopA_empty_read", 32'(bus.outsopA), 32'd0);

        // one-word packet to A
        do_reset();
        set_word(0, 32'h0000ABCD, 1'b1, 1'b1);
        step();
        chk("t2_stallA", 32'(bus.portAstall), 32'd0);
        set_idle(); rd_in[0] = 1'b1;
        step();
        set_idle();
        step();
        chk("t2_outdataA", bus.outdataA, 32'h0000ABCD);
        chk("t2_outsopA", 32'(bus.outsopA), 32'd1);
        chk("t2_outeopA", 32'(bus.outeopA), 32'd1);
        chk("t2_outsopB", 32'(bus.outsopB), 32'd0);

        // contention for output B right after reset
        do_reset();
        set_word(0, 32'h0000EFEF, 1'b1, 1'b1);
        set_word(1, 32'h0000EFEF, 1'b1, 1'b1);
        step();
        chk("t3_stallA", 32'(bus.portAstall), 32'd0);
        chk("t3_stallB", 32'(bus.portBstall), 32'd1);
        set_word(0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t3_stallB_retry", 32'(bus.portBstall), 32'd0);
        set_idle(); rd_in[1] = 1'b1;
        step();
        step();
        set_idle();
        step();
        chk("t3_outsopB_second", 32'(bus.outsopB), 32'd1);

        // unknown tag is dropped
        do_reset();
        set_word(0, 32'h00001234, 1'b1, 1'b1);
        step();
        chk("t4_stallA_drop", 32'(bus.portAstall), 32'd0);
        set_idle(); rd_in[0] = 1'b1; rd_in[1] = 1'b1;
        step();
        set_idle();
        step();
        chk("t4_outsopA", 32'(bus.outsopA), 32'd0);
        chk("t4_outsopB", 32'(bus.outsopB), 32'd0);
`ifdef ETH_SW_DROP_CNT_EN
        chk("t4_dropcntA", 32'(bus.dropcntA), 32'd1);
`endif

        // fill FIFO A, then simultaneous read and write when full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_word(0, {16'(i + 1), 16'hABCD}, 1'b1, 1'b1);
            step();
        end
        set_word(0, 32'h0009ABCD, 1'b1, 1'b1);
        step();
        chk("t5_full_stall", 32'(bus.portAstall), 32'd1);
        rd_in[0] = 1'b1;
        step();
        chk("t5_full_rdwr_accept", 32'(bus.portAstall), 32'd0);
        set_idle(); rd_in[0] = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();

        // multi-word packet from A holds output A against B
        do_reset();
        set_word(0, 32'h0000ABCD, 1'b1, 1'b0);
        step();
        set_word(0, 32'h11111111, 1'b0, 1'b0);
        set_word(1, 32'h0000ABCD, 1'b1, 1'b1);
        step();
        chk("t6_stallB_mid1", 32'(bus.portBstall), 32'd1);
        set_word(0, 32'h22222222, 1'b0, 1'b1);
        step();
        chk("t6_stallB_mid2", 32'(bus.portBstall), 32'd1);
        set_word(0, 32'h0, 1'b0, 1'b0);
        step();
        chk("t6_stallB_after_eop", 32'(bus.portBstall), 32'd0);
        set_idle(); rd_in[0] = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // randomized traffic
        do_reset();
        stuck = 1'b0;
        for (int s = 0; s < 2; s++) begin pact[s] = 1'b0; hold[s] = 0; end
        for (int cyc = 0; cyc < 3000 && !stuck; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pact[s] && $urandom_range(0, 9) < 4) begin
                    case ($urandom_range(0, 2))
                        0:       tag = 16'hABCD;
                        1:       tag = 16'hEFEF;
                        default: tag = 16'($urandom);
                    endcase
                    plen[s] = $urandom_range(1, 4);
                    for (int k = 0; k < 4; k++) begin
                        pw[s][k]  = $urandom;
                        pso[s][k] = (k == 0) || ($urandom_range(0, 7) == 0);
                    end
                    pw[s][0][15:0] = tag;
                    pact[s] = 1'b1; pidx[s] = 0; hold[s] = 0;
                end
                if (pact[s]) begin
                    set_word(s, pw[s][pidx[s]], pso[s][pidx[s]], pidx[s] == plen[s] - 1);
                end else begin
                    set_word(s, $urandom, 1'b0, 1'($urandom_range(0, 1)));
                end
                rd_in[s] = ($urandom_range(0, 9) < 6);
            end
            step();
            for (int s = 0; s < 2; s++) begin
                if (pact[s]) begin
                    if (last_acc[s]) begin
                        hold[s] = 0;
                        pidx[s]++;
                        if (pidx[s] == plen[s]) pact[s] = 1'b0;
                    end else begin
                        hold[s]++;
                        if (hold[s] > 200) begin
                            chk("liveness_stall_cycles", 32'(hold[s]), 32'd0);
                            stuck = 1'b1;
                        end
                    end
                end
            end
        end
        set_idle(); rd_in[0] = 1'b1; rd_in[1] = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
